dbg_run_ctrl: RTL and testbench

- Run-control sequencer for the 5-stage MIPS pipeline; gates fetch and freezes all stages on break button, PC breakpoint or WB overflow.
- Supports single-step and resume.
- Sits beside the hazard unit. `fetch_hold` is ORed into the PC/IF-ID stall path; `freeze` holds every pipeline register, the PC and the regfile write enable.
- Maintains cycle and retired-instruction counters for the debug display.

---
 rtl/dbg_pkg.sv | 8 +
 rtl/dbg_run_ctrl_if.sv | 26 ++
 rtl/btn_sync_edge.sv | 25 ++
 rtl/dbg_run_ctrl.sv | 99 +++++++++
 tb/tb_dbg_run_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared run-control state encoding and halt-cause codes
package dbg_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALT, STEP} state_t;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_BRK  = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_OVF  = 2'd3;
endpackage

// File: rtl/dbg_run_ctrl_if.sv
// dbg_run_ctrl_if: pipeline-facing run-control signals between core/debug host and sequencer
interface dbg_run_ctrl_if #(parameter int CNT_W = 32) ();
  logic             break_btn;
  logic             continue_btn;
  logic             step_btn;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc_if;
  logic             overflow_wb;
  logic             retire_wb;
  logic             cnt_clr;
  logic             fetch_hold;
  logic             freeze;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  modport master (
    output break_btn, continue_btn, step_btn, bp_en, bp_addr, pc_if, overflow_wb, retire_wb, cnt_clr,
    input  fetch_hold, freeze, halted, halt_cause, cycle_cnt, retire_cnt
  );
  modport slave (
    input  break_btn, continue_btn, step_btn, bp_en, bp_addr, pc_if, overflow_wb, retire_wb, cnt_clr,
    output fetch_hold, freeze, halted, halt_cause, cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: synchronizes an async button and emits a registered 1-cycle rising-edge pulse
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | SYNC_STAGES'(btn_i);
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: halts, drains, single-steps and resumes the pipeline; counts unfrozen cycles and retirements
module dbg_run_ctrl
  import dbg_pkg::*;
#(
  parameter int PIPE_DEPTH  = 5,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst_n,
  dbg_run_ctrl_if.slave bus
);
  localparam int DW = $clog2(PIPE_DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH - 2);
  state_t           state_q;
  logic [DW-1:0]    drain_q;
  logic             bp_skip_q;
  logic             halted_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retire_q;
  logic             brk_p, cont_p, step_p;
  logic             bp_hit, fetch_hold, freeze;
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_brk  (.clk(clk), .rst_n(rst_n), .btn_i(bus.break_btn),    .pulse_o(brk_p));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cont (.clk(clk), .rst_n(rst_n), .btn_i(bus.continue_btn), .pulse_o(cont_p));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step (.clk(clk), .rst_n(rst_n), .btn_i(bus.step_btn),     .pulse_o(step_p));
  // bp_skip lets a resume fetch the breakpoint address once without re-halting
  assign bp_hit     = bus.bp_en && (bus.pc_if == bus.bp_addr) && !bp_skip_q && (state_q == RUN);
  assign fetch_hold = (state_q == DRAIN) || (state_q == HALT) || bp_hit;
  assign freeze     = state_q == HALT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      drain_q   <= '0;
      bp_skip_q <= 1'b0;
      halted_q  <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      if ((state_q == RUN || state_q == STEP) && !fetch_hold) bp_skip_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.overflow_wb) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            cause_q  <= CAUSE_OVF;
          end else if (brk_p || bp_hit) begin
            state_q <= DRAIN;
            drain_q <= '0;
            cause_q <= brk_p ? CAUSE_BRK : CAUSE_BP;
          end
        end
        DRAIN: begin
          if (bus.overflow_wb || drain_q == DRAIN_LAST) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            if (bus.overflow_wb) cause_q <= CAUSE_OVF;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        HALT: begin
          if (cont_p || step_p) begin
            state_q   <= cont_p ? RUN : STEP;
            halted_q  <= 1'b0;
            bp_skip_q <= 1'b1;
            cause_q   <= CAUSE_NONE;
          end
        end
        STEP: begin
          if (bus.overflow_wb) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            cause_q  <= CAUSE_OVF;
          end else begin
            state_q <= DRAIN;
            drain_q <= '0;
            cause_q <= CAUSE_BRK;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      cycle_q  <= bus.cnt_clr ? '0 : freeze ? cycle_q : cycle_q + CNT_W'(1);
      retire_q <= bus.cnt_clr ? '0 : (bus.retire_wb && !freeze) ? retire_q + CNT_W'(1) : retire_q;
    end
  end
  assign bus.fetch_hold = fetch_hold;
  assign bus.freeze     = freeze;
  assign bus.halted     = halted_q;
  assign bus.halt_cause = cause_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_dbg_run_ctrl.sv
// tb_dbg_run_ctrl: directed run-control scenarios checked through an expectation scoreboard
module tb_dbg_run_ctrl;
  import dbg_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dbg_run_ctrl_if #(.CNT_W(32)) bus ();
  dbg_run_ctrl_if #(.CNT_W(4))  wbus ();
  dbg_run_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  dbg_run_ctrl #(.CNT_W(4)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus));
  typedef struct {
    int          at;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return {31'b0, bus.fetch_hold};
      1: return {31'b0, bus.freeze};
      2: return {31'b0, bus.halted};
      3: return {30'b0, bus.halt_cause};
      4: return bus.cycle_cnt;
      5: return bus.retire_cnt;
      6: return {28'b0, wbus.cycle_cnt};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  task automatic chk(int sel, logic [31:0] exp, string name);
    exp_t e;
    e.at = cyc;
    e.sel = sel;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(int which);
    bus.break_btn    = (which == 0);
    bus.continue_btn = (which == 1) || (which == 3);
    bus.step_btn     = (which == 2) || (which == 3);
    tick(4);
    bus.break_btn    = 1'b0;
    bus.continue_btn = 1'b0;
    bus.step_btn     = 1'b0;
  endtask
  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        a = actual(e.sel);
        checks++;
        if (e.at != cyc) begin
          errors++;
          $display("FAIL %s: sample at cycle %0d missed (now %0d)", e.name, e.at, cyc);
        end else if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
        end
      end
    end
  end
  initial begin
    {bus.break_btn, bus.continue_btn, bus.step_btn, bus.bp_en, bus.overflow_wb, bus.retire_wb, bus.cnt_clr} = '0;
    bus.bp_addr = '0;
    bus.pc_if = '0;
    {wbus.break_btn, wbus.continue_btn, wbus.step_btn, wbus.bp_en, wbus.overflow_wb, wbus.retire_wb, wbus.cnt_clr} = '0;
    wbus.bp_addr = '0;
    wbus.pc_if = 32'h4;
    tick(2);
    chk(0, 0, "rst_fetch_hold"); chk(1, 0, "rst_freeze"); chk(2, 0, "rst_halted");
    chk(3, 0, "rst_cause"); chk(4, 0, "rst_cycle"); chk(5, 0, "rst_retire");
    rst_n = 1'b1;
    bus.retire_wb = 1'b1;
    tick(10);
    chk(4, 10, "run_cycle"); chk(5, 10, "run_retire"); chk(0, 0, "run_fetch_hold"); chk(1, 0, "run_freeze");
    bus.retire_wb = 1'b0;
    bus.break_btn = 1'b1;
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    tick(2);
    chk(0, 0, "brk_before_pulse");
    tick(1);
    chk(0, 1, "brk_drain_start"); chk(2, 0, "brk_drain_not_halted");
    tick(3);
    chk(0, 1, "brk_drain_end"); chk(1, 0, "brk_drain_freeze"); chk(2, 0, "brk_drain_end_halted");
    bus.break_btn = 1'b0;
    tick(1);
    chk(2, 1, "brk_halted"); chk(1, 1, "brk_freeze"); chk(3, CAUSE_BRK, "brk_cause"); chk(4, 7, "brk_cycle");
    tick(3);
    chk(4, 7, "brk_cycle_frozen");
    bus.bp_en = 1'b1;
    bus.bp_addr = 32'h40;
    bus.pc_if = 32'h3c;
    press(1);
    chk(2, 0, "cont1_halted"); chk(0, 0, "cont1_fetch_hold");
    tick(2);
    bus.pc_if = 32'h40;
    chk(0, 1, "bp_same_cycle_hold"); chk(2, 0, "bp_same_cycle_halted");
    tick(4);
    chk(2, 0, "bp_drain_halted");
    tick(1);
    chk(2, 1, "bp_halted"); chk(3, CAUSE_BP, "bp_cause");
    press(1);
    chk(0, 0, "bp_resume_no_retrig"); chk(2, 0, "bp_resume_halted");
    tick(1);
    bus.pc_if = 32'h44;
    chk(0, 0, "bp_after_fetch_hold"); chk(2, 0, "bp_after_fetch_halted");
    tick(1);
    chk(2, 0, "bp_running");
    press(0);
    tick(4);
    chk(2, 1, "pre_step_halted");
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    chk(4, 0, "clr_cycle_halted"); chk(5, 0, "clr_retire_halted");
    press(2);
    chk(0, 0, "step_fetch"); chk(1, 0, "step_freeze"); chk(2, 0, "step_halted");
    tick(1);
    chk(0, 1, "step_drain_hold"); chk(3, CAUSE_BRK, "step_drain_cause");
    tick(2);
    bus.retire_wb = 1'b1;
    tick(1);
    bus.retire_wb = 1'b0;
    chk(2, 0, "step_drain_last");
    tick(1);
    chk(2, 1, "step_done_halted"); chk(3, CAUSE_BRK, "step_done_cause");
    chk(4, 5, "step_cycle"); chk(5, 1, "step_retire");
    press(1);
    press(0);
    tick(1);
    bus.overflow_wb = 1'b1;
    tick(1);
    bus.overflow_wb = 1'b0;
    chk(2, 1, "ovf_halted"); chk(3, CAUSE_OVF, "ovf_cause"); chk(1, 1, "ovf_freeze");
    tick(2);
    chk(2, 1, "ovf_stays_halted"); chk(3, CAUSE_OVF, "ovf_cause_holds");
    press(3);
    chk(2, 0, "contstep_halted"); chk(1, 0, "contstep_freeze");
    tick(1);
    chk(0, 0, "contstep_run");
    wbus.cnt_clr = 1'b1;
    tick(1);
    wbus.cnt_clr = 1'b0;
    chk(6, 0, "w_clr");
    tick(15);
    chk(6, 15, "w_max");
    wbus.cnt_clr = 1'b1;
    tick(1);
    wbus.cnt_clr = 1'b0;
    chk(6, 0, "w_clr_at_max");
    tick(15);
    chk(6, 15, "w_max2");
    tick(1);
    chk(6, 0, "w_wrap");
    press(0);
    tick(1);
    rst_n = 1'b0;
    chk(0, 0, "midrst_fetch_hold"); chk(2, 0, "midrst_halted"); chk(3, 0, "midrst_cause"); chk(4, 0, "midrst_cycle");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk(0, 0, "postrst_fetch_hold"); chk(2, 0, "postrst_halted"); chk(4, 5, "postrst_cycle");
    tick(2);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
